// File: rtl/data_mem_resp_if.sv
// rtl/data_mem_resp_if.sv - load/store bus between MIPS core and data-memory responder
interface data_mem_resp_if;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        stall;

  modport master (
    output memread, memwrite, addr, wdata,
    input  rdata, ready, err, stall
  );

  modport slave (
    input  memread, memwrite, addr, wdata,
    output rdata, ready, err, stall
  );
endinterface

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - word RAM responder with programmable wait states, ready pulse and stall
module data_mem_resp #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  data_mem_resp_if.slave  bus
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] eff_addr;
  logic [31:0] eff_wdata;
  logic        eff_rd;
  logic        eff_wr;
  logic [AW-1:0] idx;
  logic        bad;
  logic        enter_resp;
  logic        mem_we;
  logic        ready;

  // Live inputs are used while IDLE so a zero-wait access can complete on its accepting edge.
  assign eff_addr  = (state_q == S_IDLE) ? bus.addr     : addr_q;
  assign eff_wdata = (state_q == S_IDLE) ? bus.wdata    : wdata_q;
  assign eff_rd    = (state_q == S_IDLE) ? bus.memread  : rd_q;
  assign eff_wr    = (state_q == S_IDLE) ? bus.memwrite : wr_q;

  assign idx = eff_addr[AW+1:2];
  assign bad = (|eff_addr[1:0]) | (|eff_addr[31:AW+2]) | (eff_rd & eff_wr);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    rdata_d    = 32'h0;
    err_d      = 1'b0;
    enter_resp = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.memread | bus.memwrite) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          rd_d    = bus.memread;
          wr_d    = bus.memwrite;
          cnt_d   = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (enter_resp) begin
      err_d   = bad;
      rdata_d = (eff_rd & ~bad) ? mem[idx] : 32'h0;
    end
  end

  assign mem_we = enter_resp & eff_wr & ~bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM is not reset; a store coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[idx] <= eff_wdata;
    end
  end

  assign ready     = (state_q == S_RESP);
  assign bus.ready = ready;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  assign bus.stall = (bus.memread | bus.memwrite) & ~ready;

endmodule
